spi_slave_ram_if: RTL

//  SPI slave front end for the single-port RAM. Deserialises MOSI frames into the RAM's 10-bit

---
 rtl/spi_slave_ram_if.sv | 126 ++++++++++++
 1 files changed

// File: rtl/spi_slave_ram_if.sv
// spi_slave_ram_if: SPI slave front end for the single-port RAM.
// Receives (DATA_W+2)-bit command frames on MOSI and serialises RAM read data back on MISO.
// Optional frame-error strobe: define SPI_SLV_FRAME_ERR_EN.
module spi_slave_ram_if #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_SLV_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);
    localparam int FW = DATA_W + 2;
    localparam int CW = $clog2(FW + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;

    state_t            state_q;
    logic [FW-2:0]     sh_q;
    logic [DATA_W-2:0] tx_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     tcnt_q;
    logic              miso_q;
    logic [FW-1:0]     rx_data_q;
    logic              rx_valid_q;
    logic              abort;
    logic              timeout;

    assign abort    = ss_n && (state_q == RECV || state_q == WAIT_TX || state_q == SEND);
    assign timeout  = state_q == WAIT_TX && !tx_valid && tcnt_q == TW'(TX_TIMEOUT - 1);
    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    // Frame state machine: receive command, optionally wait for RAM data and shift it out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            tx_q       <= '0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                miso_q  <= 1'b0;
                cnt_q   <= '0;
                tcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!ss_n) begin
                            state_q <= RECV;
                            cnt_q   <= '0;
                        end
                    end
                    RECV: begin
                        sh_q  <= {sh_q[FW-3:0], mosi};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(FW - 1)) begin
                            rx_data_q  <= {sh_q, mosi};
                            rx_valid_q <= 1'b1;
                            cnt_q      <= '0;
                            tcnt_q     <= '0;
                            state_q    <= (sh_q[FW-2:FW-3] == 2'b11) ? WAIT_TX : DONE;
                        end
                    end
                    WAIT_TX: begin
                        if (tx_valid) begin
                            tx_q    <= tx_data[DATA_W-2:0];
                            miso_q  <= tx_data[DATA_W-1];
                            cnt_q   <= '0;
                            state_q <= SEND;
                        end else if (timeout) begin
                            miso_q  <= 1'b0;
                            tcnt_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                    SEND: begin
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            miso_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            miso_q <= tx_q[DATA_W-2];
                            tx_q   <= tx_q << 1;
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        miso_q <= 1'b0;
                        if (ss_n) state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_SLV_FRAME_ERR_EN
    logic frame_err_q;
    assign frame_err = frame_err_q;

    // One-cycle error strobe registered with the abort/timeout state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= abort || timeout;
    end
`endif
endmodule
